yuv422_axis_downsizer: RTL and testbench
========================================

// Module: yuv422_axis_downsizer
// PURPOSE
//  Downstream of YUV_2xy_scaler; consumes its 4-pix/clk YUV422 AXI-stream (64b beat = 4 x {C,Y} 16b pixels).
//  Serialises each wide beat into OUT_PPC-pixel beats for the 1-pix/clk output/record path, propagating tuser/tlast.
//  Checks output line length against LINE_PIX and raises a sticky error flag on mismatch.
// PARAMETERS
//  data_width        8     bits per component; pixel = 2*data_width (YUV422 {C,Y})
//  in_pix_per_clock  4     pixels per input beat
//  out_pix_per_clock 1     pixels per output beat; must divide in_pix_per_clock
//  LINE_PIX          1920  expected output pixels per line (tlast period), for checker
// PORTS
//  clk_in    in   1                          single clock, all logic rising edge
//  reset     in   1                          asynchronous, active-low reset
//  rdata     in   in_pix_per_clock*2*dw      input beat, pixel 0 in LSBs
//  rvalid    in   1                          input valid
//  rready    out  1                          input ready
//  ruser     in   1                          start of frame (with first beat)
//  rlast     in   1                          end of line (with last beat of line)
//  tdata     out  out_pix_per_clock*2*dw     output beat, lowest-index pixel in LSBs
//  tvalid    out  1                          output valid
//  tready    in   1                          output ready
//  tuser     out  1                          start of frame, first output beat only
//  tlast     out  1                          end of line, final output beat of rlast beat only
//  line_err  out  1                          sticky: a line length != LINE_PIX seen
//  clr_err   in   1                          sync clear of line_err
// BEHAVIOUR
//  RATIO = in_pix_per_clock/out_pix_per_clock; phase counter width clog2(RATIO) (min 1).
//  Reset (reset=0): all registers cleared; tvalid=0, tdata=0, tuser=0, tlast=0, line_err=0, rready=0.
//  States: EMPTY (no beat held), HOLD (beat in buffer, phase 0..RATIO-1).
//  rready = (state==EMPTY) | (state==HOLD & phase==RATIO-1 & tready); 0 while reset asserted.
//  Accept (rvalid&rready): latch rdata/ruser/rlast, phase<=0, state<=HOLD; latency accept->tvalid = 1 clk.
//  HOLD: tvalid=1; tdata = buffer slice [phase*W_OUT +: W_OUT]; phase advances only on tready.
//  Last phase & tready: if rvalid, load next beat in same cycle (no bubble, 100% throughput); else EMPTY.
//  tuser = held ruser & phase==0; tlast = held rlast & phase==RATIO-1.
//  Output stable while tvalid&!tready (AXI-stream rule); tvalid never drops without handshake.
//  Checker: pix_cnt (16b) += out_pix_per_clock per output handshake; on tlast handshake compare
//   pix_cnt+out_pix_per_clock with LINE_PIX, set line_err on mismatch, pix_cnt<=0.
//  tuser handshake resets pix_cnt to out_pix_per_clock (new frame restarts the line count).
//  pix_cnt saturates at 0xFFFF (no wrap; missing tlast yields mismatch, not false match).
//  clr_err and a mismatch in same cycle: set wins. RATIO==1: pure register slice, same rules.
//  Reset mid-beat: held beat discarded, no partial output after release.
// STRUCTURE
//  Shared package yuv_axis_pkg: pixel width function (2*data_width), clog2 helper, phase/state encodings.
//  One sub-module natural: yuv_line_len_checker (pix_cnt, compare, sticky line_err).
//  Datapath/FSM in top; no FIFO beyond the single beat buffer.
// TESTING
//  1. rdata=64'h0807_0605_0403_0201, tready=1 -> tdata 16'h0201,0403,0605,0807 on 4 consecutive clks; rready low 3 clks.
//  2. Back-to-back 4 beats, rvalid=1 always, tready=1 -> 16 output beats, no tvalid gaps, rready high every 4th clk.
//  3. tready toggled 1/0 random -> tdata/tuser/tlast held while stalled; output order identical to test 1.
//  4. ruser=1 on beat A, rlast=1 on beat B -> tuser only on A pixel0, tlast only on B pixel3.
//  5. LINE_PIX=8: line of 2 beats -> line_err=0; line of 3 beats -> line_err=1, stays 1 until clr_err.
//  6. Assert reset during phase 2 -> tvalid=0 next edge; after release next beat output starts at its pixel0.

Source files
------------

// File: rtl/yuv_axis_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// yuv_axis_pkg : shared widths, clog2 helper and beat-buffer state encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
package yuv_axis_pkg;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  function automatic int pix_width(input int dw);
    return 2 * dw;
  endfunction

  // Never returns 0 so that a RATIO of 1 still gets a legal 1-bit phase counter.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/yuv_line_len_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// yuv_line_len_checker : counts output pixels per line, sticky length error
// Revision: 1.0
// ---------------------------------------------------------------------------
module yuv_line_len_checker #(
  parameter int OUT_PIX  = 1,
  parameter int LINE_PIX = 1920
) (
  input  logic clk_in,
  input  logic reset,
  input  logic beat_hs,
  input  logic beat_user,
  input  logic beat_last,
  input  logic clr_err,
  output logic line_err
);

  localparam logic [16:0] INC  = 17'(OUT_PIX);
  localparam logic [16:0] LINE = 17'(LINE_PIX);

  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic        line_err_q, line_err_d;
  logic [16:0] sum;
  logic [15:0] sum_sat;
  logic        mismatch;

  always_comb begin
    // A start-of-frame beat restarts the count from its own pixels.
    sum        = (beat_user ? 17'd0 : {1'b0, pix_cnt_q}) + INC;
    sum_sat    = sum[16] ? 16'hFFFF : sum[15:0];
    mismatch   = beat_hs & beat_last & ({1'b0, sum_sat} != LINE);
    pix_cnt_d  = pix_cnt_q;
    if (beat_hs) begin
      pix_cnt_d = beat_last ? 16'd0 : sum_sat;
    end
    line_err_d = line_err_q;
    if (clr_err)  line_err_d = 1'b0;
    if (mismatch) line_err_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      pix_cnt_q  <= 16'd0;
      line_err_q <= 1'b0;
    end else begin
      pix_cnt_q  <= pix_cnt_d;
      line_err_q <= line_err_d;
    end
  end

  assign line_err = line_err_q;

endmodule
`default_nettype wire

// File: rtl/yuv422_axis_downsizer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// yuv422_axis_downsizer : serialises wide YUV422 beats into narrow beats
// Revision: 1.0
// ---------------------------------------------------------------------------
module yuv422_axis_downsizer
  import yuv_axis_pkg::*;
#(
  parameter int data_width        = 8,
  parameter int in_pix_per_clock  = 4,
  parameter int out_pix_per_clock = 1,
  parameter int LINE_PIX          = 1920
) (
  input  logic                                         clk_in,
  input  logic                                         reset,
  input  logic [in_pix_per_clock*2*data_width-1:0]     rdata,
  input  logic                                         rvalid,
  output logic                                         rready,
  input  logic                                         ruser,
  input  logic                                         rlast,
  output logic [out_pix_per_clock*2*data_width-1:0]    tdata,
  output logic                                         tvalid,
  input  logic                                         tready,
  output logic                                         tuser,
  output logic                                         tlast,
  output logic                                         line_err,
  input  logic                                         clr_err
);

  localparam int RATIO = in_pix_per_clock / out_pix_per_clock;
  localparam int PH_W  = clog2_min1(RATIO);
  localparam int W_PIX = pix_width(data_width);
  localparam int W_IN  = in_pix_per_clock * W_PIX;
  localparam int W_OUT = out_pix_per_clock * W_PIX;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(RATIO - 1);

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [W_IN-1:0]   buf_q, buf_d;
  logic              user_q, user_d;
  logic              last_q, last_d;
  logic              hold, phase_end, accept, out_hs;

  assign hold      = (state_q == ST_HOLD);
  assign phase_end = (phase_q == PH_LAST);
  // Gated with reset so no beat is offered to while the block is held in reset.
  assign rready    = reset & (~hold | (phase_end & tready));
  assign accept    = rvalid & rready;
  assign out_hs    = hold & tready;
  assign tvalid    = hold;
  assign tuser     = hold & user_q & (phase_q == '0);
  assign tlast     = hold & last_q & phase_end;

  generate
    if (RATIO == 1) begin : g_ratio_one
      assign tdata = hold ? buf_q[W_OUT-1:0] : '0;
    end else begin : g_ratio_multi
      int slice_lo;
      always_comb slice_lo = int'(phase_q) * W_OUT;
      assign tdata = hold ? buf_q[slice_lo +: W_OUT] : '0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    buf_d   = buf_q;
    user_d  = user_q;
    last_d  = last_q;
    if (out_hs) begin
      if (phase_end) begin
        state_d = ST_EMPTY;
        phase_d = '0;
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
    end
    // A load on the final phase overrides the drain, giving back-to-back beats.
    if (accept) begin
      buf_d   = rdata;
      user_d  = ruser;
      last_d  = rlast;
      phase_d = '0;
      state_d = ST_HOLD;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      phase_q <= '0;
      buf_q   <= '0;
      user_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      buf_q   <= buf_d;
      user_q  <= user_d;
      last_q  <= last_d;
    end
  end

  yuv_line_len_checker #(
    .OUT_PIX  (out_pix_per_clock),
    .LINE_PIX (LINE_PIX)
  ) u_line_chk (
    .clk_in    (clk_in),
    .reset     (reset),
    .beat_hs   (out_hs),
    .beat_user (tuser),
    .beat_last (tlast),
    .clr_err   (clr_err),
    .line_err  (line_err)
  );

endmodule
`default_nettype wire

// File: tb/tb_yuv422_axis_downsizer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_yuv422_axis_downsizer : directed table-driven bench, LINE_PIX = 8
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_yuv422_axis_downsizer;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  typedef struct {
    logic        rv;
    logic [63:0] rd;
    logic        ru;
    logic        rl;
    logic        tr;
    logic        clr;
    logic        etv;
    logic [15:0] etd;
    logic        etu;
    logic        etl;
    logic        erdy;
    logic        eerr;
  } vec_t;

  logic        clk_in;
  logic        reset;
  logic [63:0] rdata;
  logic        rvalid;
  logic        rready;
  logic        ruser;
  logic        rlast;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;
  logic        line_err;
  logic        clr_err;

  int n_checks;
  int n_fail;

  vec_t tbl[$];

  yuv422_axis_downsizer #(
    .data_width        (8),
    .in_pix_per_clock  (4),
    .out_pix_per_clock (1),
    .LINE_PIX          (8)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .rready   (rready),
    .ruser    (ruser),
    .rlast    (rlast),
    .tdata    (tdata),
    .tvalid   (tvalid),
    .tready   (tready),
    .tuser    (tuser),
    .tlast    (tlast),
    .line_err (line_err),
    .clr_err  (clr_err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rv, input logic [63:0] rd, input logic ru,
                              input logic rl, input logic tr, input logic clr,
                              input logic etv, input logic [15:0] etd, input logic etu,
                              input logic etl, input logic erdy, input logic eerr);
    vec_t v;
    v.rv = rv; v.rd = rd; v.ru = ru; v.rl = rl; v.tr = tr; v.clr = clr;
    v.etv = etv; v.etd = etd; v.etu = etu; v.etl = etl; v.erdy = erdy; v.eerr = eerr;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag, input int idx);
    @(negedge clk_in);
    rvalid  = v.rv;
    rdata   = v.rd;
    ruser   = v.ru;
    rlast   = v.rl;
    tready  = v.tr;
    clr_err = v.clr;
    #1;
    chk($sformatf("%s[%0d].tvalid", tag, idx), {63'd0, tvalid}, {63'd0, v.etv});
    chk($sformatf("%s[%0d].tdata", tag, idx), {48'd0, tdata}, {48'd0, v.etd});
    chk($sformatf("%s[%0d].tuser", tag, idx), {63'd0, tuser}, {63'd0, v.etu});
    chk($sformatf("%s[%0d].tlast", tag, idx), {63'd0, tlast}, {63'd0, v.etl});
    chk($sformatf("%s[%0d].rready", tag, idx), {63'd0, rready}, {63'd0, v.erdy});
    chk($sformatf("%s[%0d].line_err", tag, idx), {63'd0, line_err}, {63'd0, v.eerr});
  endtask

  initial begin
    logic [63:0] d1, a, b, c, d2, e, f, g;
    logic [63:0] bb [4];
    int idx;
    int j;
    int cyc;
    logic exp_rdy;
    logic exp_tv;

    n_checks = 0;
    n_fail   = 0;
    d1 = 64'h0807_0605_0403_0201;
    a  = 64'h1817_1615_1413_1211;
    b  = 64'h2827_2625_2423_2221;
    c  = 64'h3837_3635_3433_3231;
    d2 = 64'h4847_4645_4443_4241;
    e  = 64'h5857_5655_5453_5251;
    f  = 64'h6867_6665_6463_6261;
    g  = 64'h7877_7675_7473_7271;

    // single beat, 4 pixels out in LSB-first order
    tbl.push_back(mk(H, d1, L, L, H, L, L, 16'h0000, L, L, H, L));
    tbl.push_back(mk(L, 64'd0, L, L, H, L, H, 16'h0201, L, L, L, L));
    tbl.push_back(mk(L, 64'd0, L, L, H, L, H, 16'h0403, L, L, L, L));
    tbl.push_back(mk(L, 64'd0, L, L, H, L, H, 16'h0605, L, L, L, L));
    tbl.push_back(mk(L, 64'd0, L, L, H, L, H, 16'h0807, L, L, H, L));
    // two-beat line of 8 pixels: tuser on A pixel0, tlast on B pixel3, no error
    tbl.push_back(mk(H, a, H, L, H, L, L, 16'h0000, L, L, H, L));
    tbl.push_back(mk(H, b, L, H, H, L, H, 16'h1211, H, L, L, L));
    tbl.push_back(mk(H, b, L, H, H, L, H, 16'h1413, L, L, L, L));
    tbl.push_back(mk(H, b, L, H, H, L, H, 16'h1615, L, L, L, L));
    tbl.push_back(mk(H, b, L, H, H, L, H, 16'h1817, L, L, H, L));
    tbl.push_back(mk(L, 64'd0, L, L, H, L, H, 16'h2221, L, L, L, L));
    tbl.push_back(mk(L, 64'd0, L, L, H, L, H, 16'h2423, L, L, L, L));
    tbl.push_back(mk(L, 64'd0, L, L, H, L, H, 16'h2625, L, L, L, L));
    tbl.push_back(mk(L, 64'd0, L, L, H, L, H, 16'h2827, L, H, H, L));
    tbl.push_back(mk(L, 64'd0, L, L, H, L, L, 16'h0000, L, L, H, L));
    // three-beat line of 12 pixels -> sticky error until cleared
    tbl.push_back(mk(H, c, L, L, H, L, L, 16'h0000, L, L, H, L));
    tbl.push_back(mk(H, d2, L, L, H, L, H, 16'h3231, L, L, L, L));
    tbl.push_back(mk(H, d2, L, L, H, L, H, 16'h3433, L, L, L, L));
    tbl.push_back(mk(H, d2, L, L, H, L, H, 16'h3635, L, L, L, L));
    tbl.push_back(mk(H, d2, L, L, H, L, H, 16'h3837, L, L, H, L));
    tbl.push_back(mk(H, e, L, H, H, L, H, 16'h4241, L, L, L, L));
    tbl.push_back(mk(H, e, L, H, H, L, H, 16'h4443, L, L, L, L));
    tbl.push_back(mk(H, e, L, H, H, L, H, 16'h4645, L, L, L, L));
    tbl.push_back(mk(H, e, L, H, H, L, H, 16'h4847, L, L, H, L));
    tbl.push_back(mk(L, 64'd0, L, L, H, L, H, 16'h5251, L, L, L, L));
    tbl.push_back(mk(L, 64'd0, L, L, H, L, H, 16'h5453, L, L, L, L));
    tbl.push_back(mk(L, 64'd0, L, L, H, L, H, 16'h5655, L, L, L, L));
    tbl.push_back(mk(L, 64'd0, L, L, H, L, H, 16'h5857, L, H, H, L));
    tbl.push_back(mk(L, 64'd0, L, L, H, L, L, 16'h0000, L, L, H, H));
    tbl.push_back(mk(L, 64'd0, L, L, L, L, L, 16'h0000, L, L, H, H));
    tbl.push_back(mk(L, 64'd0, L, L, H, H, L, 16'h0000, L, L, H, H));
    tbl.push_back(mk(L, 64'd0, L, L, H, L, L, 16'h0000, L, L, H, L));

    // reset state
    reset = 1'b0; rdata = 64'd0; rvalid = 1'b0; ruser = 1'b0; rlast = 1'b0;
    tready = 1'b0; clr_err = 1'b0;
    @(negedge clk_in);
    #1;
    chk("rst.tvalid", {63'd0, tvalid}, 64'd0);
    chk("rst.tdata", {48'd0, tdata}, 64'd0);
    chk("rst.tuser", {63'd0, tuser}, 64'd0);
    chk("rst.tlast", {63'd0, tlast}, 64'd0);
    chk("rst.rready", {63'd0, rready}, 64'd0);
    chk("rst.line_err", {63'd0, line_err}, 64'd0);
    @(negedge clk_in);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], "vec", i);

    // back-to-back beats with rvalid held: no output gaps
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 4; p++) bb[k][16*p +: 16] = 16'hA000 + 16'(k * 256) + 16'(p);
    end
    idx = 0;
    for (int cc = 0; cc < 18; cc++) begin
      @(negedge clk_in);
      rvalid  = (idx < 4);
      rdata   = (idx < 4) ? bb[idx] : 64'd0;
      ruser   = 1'b0;
      rlast   = 1'b0;
      tready  = 1'b1;
      clr_err = 1'b0;
      #1;
      exp_rdy = ((cc % 4) == 0) || (cc == 17);
      exp_tv  = (cc >= 1) && (cc <= 16);
      chk($sformatf("b2b[%0d].rready", cc), {63'd0, rready}, {63'd0, exp_rdy});
      chk($sformatf("b2b[%0d].tvalid", cc), {63'd0, tvalid}, {63'd0, exp_tv});
      if (exp_tv)
        chk($sformatf("b2b[%0d].tdata", cc), {48'd0, tdata}, {48'd0, bb[(cc-1)/4][16*((cc-1)%4) +: 16]});
      if (exp_rdy && rvalid) idx++;
    end

    // random back-pressure: outputs must hold while stalled
    @(negedge clk_in);
    rvalid = 1'b1; rdata = d1; ruser = 1'b1; rlast = 1'b1; tready = 1'b0;
    #1;
    chk("stall.accept_rready", {63'd0, rready}, 64'd1);
    j = 0;
    cyc = 0;
    while (j < 4 && cyc < 64) begin
      @(negedge clk_in);
      rvalid = 1'b0; ruser = 1'b0; rlast = 1'b0; rdata = 64'd0;
      tready = (cyc < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("stall[%0d].tvalid", cyc), {63'd0, tvalid}, 64'd1);
      chk($sformatf("stall[%0d].tdata", cyc), {48'd0, tdata}, {48'd0, d1[16*j +: 16]});
      chk($sformatf("stall[%0d].tuser", cyc), {63'd0, tuser}, {63'd0, (j == 0)});
      chk($sformatf("stall[%0d].tlast", cyc), {63'd0, tlast}, {63'd0, (j == 3)});
      if (tready) j++;
      cyc++;
    end
    if (j < 4) chk("stall.timeout", 64'(j), 64'd4);
    @(negedge clk_in);
    tready = 1'b1;
    #1;
    chk("stall.done_tvalid", {63'd0, tvalid}, 64'd0);
    chk("stall.short_line_err", {63'd0, line_err}, 64'd1);

    // reset asserted while beat F sits at phase 2
    @(negedge clk_in);
    rvalid = 1'b1; rdata = f; tready = 1'b1;
    @(negedge clk_in);
    rvalid = 1'b0; rdata = 64'd0;
    #1;
    chk("rmid.f0", {48'd0, tdata}, 64'h6261);
    @(negedge clk_in);
    #1;
    chk("rmid.f1", {48'd0, tdata}, 64'h6463);
    @(negedge clk_in);
    reset = 1'b0;
    #1;
    chk("rmid.tvalid", {63'd0, tvalid}, 64'd0);
    chk("rmid.tdata", {48'd0, tdata}, 64'd0);
    chk("rmid.rready", {63'd0, rready}, 64'd0);
    chk("rmid.line_err", {63'd0, line_err}, 64'd0);
    @(negedge clk_in);
    reset = 1'b1;
    #1;
    chk("rrel.tvalid", {63'd0, tvalid}, 64'd0);
    chk("rrel.rready", {63'd0, rready}, 64'd1);
    apply(mk(H, g, L, L, H, L, L, 16'h0000, L, L, H, L), "post", 0);
    apply(mk(L, 64'd0, L, L, H, L, H, 16'h7271, L, L, L, L), "post", 1);
    apply(mk(L, 64'd0, L, L, H, L, H, 16'h7473, L, L, L, L), "post", 2);
    apply(mk(L, 64'd0, L, L, H, L, H, 16'h7675, L, L, L, L), "post", 3);
    apply(mk(L, 64'd0, L, L, H, L, H, 16'h7877, L, L, H, L), "post", 4);
    apply(mk(L, 64'd0, L, L, H, L, L, 16'h0000, L, L, H, L), "post", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
